// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Each operation goes through IDLE -> EXEC -> RESP, so at most one op is in flight every 3 cycles.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [3:0]       req0_sel,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [3:0]       req1_sel,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_err,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err,

    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             gnt_q, gnt_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [3:0]       sel_q, sel_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             gnt0, gnt1;
    logic             rsp_hs;

    // A lone valid requester wins regardless of the pointer.
    assign gnt0   = req0_valid && (!req1_valid || !ptr_q);
    assign gnt1   = req1_valid && (!req0_valid ||  ptr_q);
    assign rsp_hs = gnt_q ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            sel_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sel_d   = sel_q;
        res_d   = res_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d = EXEC;
                    gnt_d   = gnt1;
                    op1_d   = gnt1 ? req1_op1 : req0_op1;
                    op2_d   = gnt1 ? req1_op2 : req0_op2;
                    sel_d   = gnt1 ? req1_sel : req0_sel;
                end
            end
            EXEC: begin
                state_d = RESP;
                res_d   = alu_result;
                zero_d  = alu_zero;
                err_d   = !(sel_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100});
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                    ptr_d   = !gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready  = (state_q == IDLE) && gnt0;
        req1_ready  = (state_q == IDLE) && gnt1;
        rsp0_valid  = (state_q == RESP) && !gnt_q;
        rsp1_valid  = (state_q == RESP) &&  gnt_q;
        busy        = (state_q != IDLE);
        rsp0_result = res_q;
        rsp0_zero   = zero_q;
        rsp0_err    = err_q;
        rsp1_result = res_q;
        rsp1_zero   = zero_q;
        rsp1_err    = err_q;
        alu_op1     = op1_q;
        alu_op2     = op2_q;
        alu_sel     = sel_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with a behavioural shared-ALU and round-robin model.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [3:0]   req0_sel, req1_sel;
    logic         rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic         rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic [W-1:0] alu_op1, alu_op2, alu_result;
    logic [3:0]   alu_sel;
    logic         alu_zero;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    bit mptr  = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] s);
        case (s)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'b1100: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    function automatic bit ref_err(input logic [3:0] s);
        return !(s == 4'd0 || s == 4'd1 || s == 4'd2 || s == 4'd6 || s == 4'd7 || s == 4'd12);
    endfunction

    assign alu_result = ref_alu(alu_op1, alu_op2, alu_sel);
    assign alu_zero   = (alu_result == '0);

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
        .req0_op2(req0_op2), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
        .req1_op2(req1_op2), .req1_sel(req1_sel),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction starting just after a falling edge; the model picks the winner.
    task automatic serve(input bit v0, input bit v1,
                         input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [3:0] s0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [3:0] s1,
                         input int hold);
        int g;
        logic [W-1:0] ea, eb, er;
        logic [3:0]   es;
        req0_valid = v0; req0_op1 = a0; req0_op2 = b0; req0_sel = s0;
        req1_valid = v1; req1_op1 = a1; req1_op2 = b1; req1_sel = s1;
        #1;
        g  = (v0 && v1) ? int'(mptr) : (v0 ? 0 : 1);
        ea = (g == 1) ? a1 : a0;
        eb = (g == 1) ? b1 : b0;
        es = (g == 1) ? s1 : s0;
        er = ref_alu(ea, eb, es);
        chk("idle_ready0", req0_ready, g == 0);
        chk("idle_ready1", req1_ready, g == 1);
        chk("idle_busy", busy, 0);
        @(posedge clk);
        @(negedge clk); #1;
        chk("exec_busy", busy, 1);
        chk("exec_ready", {req0_ready, req1_ready}, 0);
        chk("exec_rspv", {rsp0_valid, rsp1_valid}, 0);
        chk("exec_alu_op1", alu_op1, ea);
        chk("exec_alu_op2", alu_op2, eb);
        chk("exec_alu_sel", alu_sel, es);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        for (int i = 0; i <= hold; i++) begin
            chk("resp_valid", {rsp0_valid, rsp1_valid}, (g == 0) ? 2'b10 : 2'b01);
            chk("resp_result", (g == 1) ? rsp1_result : rsp0_result, er);
            chk("resp_zero", (g == 1) ? rsp1_zero : rsp0_zero, er == '0);
            chk("resp_err", (g == 1) ? rsp1_err : rsp0_err, ref_err(es));
            chk("resp_busy", busy, 1);
            chk("resp_ready", {req0_ready, req1_ready}, 0);
            if (i < hold) begin
                // Offer a competing request and the wrong consumer's ready; both must be ignored.
                if (g == 0) begin req1_valid = 1'b1; rsp1_ready = 1'b1; end
                else        begin req0_valid = 1'b1; rsp0_ready = 1'b1; end
                @(negedge clk); #1;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = (g == 0); rsp1_ready = (g == 1);
        @(posedge clk);
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        chk("done_busy", busy, 0);
        chk("done_rspv", {rsp0_valid, rsp1_valid}, 0);
        mptr = (g == 0);
    endtask

    initial begin
        logic [3:0] legal [6];
        logic [3:0] s0, s1;
        int         pat;
        legal = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

        reset = 1'b1;
        req0_valid = 1'b0; req0_op1 = '0; req0_op2 = '0; req0_sel = '0;
        req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0; req1_sel = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        chk("rst_rspv", {rsp0_valid, rsp1_valid}, 0);
        chk("rst_alu_op1", alu_op1, 0);
        chk("rst_alu_op2", alu_op2, 0);
        chk("rst_alu_sel", alu_sel, 0);
        @(negedge clk);
        reset = 1'b0;
        mptr  = 1'b0;

        // Both requesters contending from reset: grants alternate 0,1,0,1.
        for (int k = 0; k < 4; k++)
            serve(1, 1, W'(k + 10), W'(4), 4'b0010, W'(k + 20), W'(3), 4'b0110, 0);

        serve(1, 0, W'(5), W'(3), 4'b0010, '0, '0, '0, 0);
        serve(0, 1, '0, '0, '0, W'(7), W'(7), 4'b0110, 0);
        serve(1, 0, W'(9), W'(4), 4'b0011, '0, '0, '0, 0);
        serve(1, 0, W'(100), W'(23), 4'b0110, '0, '0, '0, 5);

        // A request withdrawn before any rising edge leaves the block idle.
        req0_valid = 1'b1; req0_op1 = W'(1); req0_op2 = W'(2); req0_sel = 4'b0010;
        #1;
        chk("drop_ready", req0_ready, 1);
        #1;
        req0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        chk("drop_busy", busy, 0);
        chk("drop_alu_op1", alu_op1, W'(100));

        // Pointer now favours requester 1; abort a req1 op in EXEC with reset.
        req1_valid = 1'b1; req1_op1 = W'(33); req1_op2 = W'(44); req1_sel = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rspv", {rsp0_valid, rsp1_valid}, 0);
        chk("abort_alu_op1", alu_op1, 0);
        chk("abort_alu_op2", alu_op2, 0);
        chk("abort_alu_sel", alu_sel, 0);
        @(negedge clk);
        reset = 1'b0;
        mptr  = 1'b0;
        #1;
        chk("abort_after_rspv", {rsp0_valid, rsp1_valid}, 0);
        serve(1, 1, W'(6), W'(6), 4'b0000, W'(8), W'(8), 4'b0001, 0);

        for (int k = 0; k < 40; k++) begin
            pat = $urandom_range(1, 3);
            s0 = ($urandom_range(0, 1) == 1) ? legal[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
            s1 = ($urandom_range(0, 1) == 1) ? legal[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
            serve(pat[0], pat[1], W'($urandom), W'($urandom), s0,
                  W'($urandom_range(0, 3)), W'($urandom_range(0, 3)), s1, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
